// File: rtl/conbus_sched5.sv
`timescale 1ns/1ps
// conbus_sched5: five-master shared-bus arbiter.
// A master keeps the bus while it holds its cyc line. Once it has completed
// QUOTA acknowledged transfers, it yields on a terminal (non-burst) ack if
// another master is waiting. A wait-state watchdog pulses timeout when the
// owner has strobed for TIMEOUT cycles without an ack. The watchdog never
// changes the grant.
module conbus_sched5 #(
  parameter int QUOTA   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [4:0] req,
  input  logic       bus_stb,
  input  logic       bus_ack,
  input  logic [2:0] bus_cti,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       timeout
);

  // The tenure counter saturates at QUOTA, so it needs to hold 0..QUOTA.
  // The wait counter wraps at TIMEOUT-1, so it needs to hold 0..TIMEOUT-1.
  localparam int QW = (QUOTA > 1) ? $clog2(QUOTA + 1) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [QW-1:0] Q_MAX  = QW'(QUOTA);
  localparam logic [QW-1:0] Q_LAST = QW'(QUOTA - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  logic [QW-1:0] tenure_cnt;
  logic [TW-1:0] wait_cnt;

  logic [2:0] any_idx;
  logic       any_found;
  logic [2:0] other_idx;
  logic       other_found;
  logic       terminal_cti;
  logic       preempt;
  logic       wait_cycle;

  // Index arithmetic modulo 5. base is always 0..4 and step is 1..5.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= 5) sum = sum - 5;
    return 3'(sum);
  endfunction

  // Cyclic search starting at gnt+1. any_* may end on gnt itself;
  // other_* skips the current owner and is used for preemption.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    any_found   = 1'b0;
    any_idx     = gnt;
    other_found = 1'b0;
    other_idx   = gnt;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 5; k >= 1; k--) begin
      if (req[wrap_add(gnt, k)]) begin
        any_found = 1'b1;
        any_idx   = wrap_add(gnt, k);
        if (k < 5) begin
          other_found = 1'b1;
          other_idx   = wrap_add(gnt, k);
        end
      end
    end
  end

  // cti 000 (classic) and 111 (end of burst) are the only safe hand-over points.
  assign terminal_cti = (bus_cti == 3'b000) || (bus_cti == 3'b111);
  assign preempt      = req[gnt] && bus_ack && terminal_cti &&
                        (tenure_cnt >= Q_LAST) && other_found;
  assign wait_cycle   = busy && bus_stb && !bus_ack;

  // Arbitration FSM with registered gnt/busy/timeout and both counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: state registers use non-blocking assignments so every read in
    // this block sees the pre-edge value, whatever the statement order.
    if (sys_rst) begin
      state      <= PARK;
      gnt        <= 3'd0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      tenure_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        PARK: begin
          tenure_cnt <= '0;
          wait_cnt   <= '0;
          if (any_found) begin
            gnt   <= any_idx;
            state <= OWN;
            busy  <= 1'b1;
          end
        end
        OWN: begin
          if (!req[gnt]) begin
            // Release. A simultaneous ack is treated the same way.
            tenure_cnt <= '0;
            wait_cnt   <= '0;
            if (any_found) begin
              gnt <= any_idx;
            end else begin
              state <= PARK;
              busy  <= 1'b0;
            end
          end else if (preempt) begin
            gnt        <= other_idx;
            tenure_cnt <= '0;
            wait_cnt   <= '0;
          end else begin
            if (bus_ack && (tenure_cnt != Q_MAX)) begin
              tenure_cnt <= tenure_cnt + 1'b1;
            end
            if (wait_cycle) begin
              if (wait_cnt == T_LAST) begin
                wait_cnt <= '0;
                timeout  <= 1'b1;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end else begin
              wait_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conbus_sched5.sv
`timescale 1ns/1ps
// Self-checking bench for conbus_sched5: directed vectors with hand-computed
// expectations plus a transaction-level model checked after every clock edge.
module tb_conbus_sched5;

  localparam int QUOTA   = 8;
  localparam int TIMEOUT = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [4:0] req     = 5'b0;
  logic       bus_stb = 1'b0;
  logic       bus_ack = 1'b0;
  logic [2:0] bus_cti = 3'b0;
  logic [2:0] gnt;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  conbus_sched5 #(.QUOTA(QUOTA), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .bus_stb (bus_stb),
    .bus_ack (bus_ack),
    .bus_cti (bus_cti),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Model state: who owns the bus, acks completed this tenure, wait cycles
  // seen so far, and whether the watchdog fired on the last edge.
  typedef struct {
    int g;
    bit own;
    int acks;
    int waits;
    bit pulse;
  } mstate_t;

  mstate_t m = '{default: 0};

  // First requester after position 'from', walking upward modulo 5.
  function automatic int next_req(logic [4:0] r, int from, bit incl_self);
    int res;
    int lim;
    res = -1;
    lim = incl_self ? 5 : 4;
    for (int k = 1; k <= lim; k++) begin
      if (res < 0 && r[(from + k) % 5]) res = (from + k) % 5;
    end
    return res;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic [4:0] r, logic stb,
                                         logic ack, logic [2:0] cti);
    mstate_t n;
    n       = s;
    n.pulse = 1'b0;
    if (!s.own) begin
      n.acks  = 0;
      n.waits = 0;
      if (r != 5'b0) begin
        n.g   = next_req(r, s.g, 1'b1);
        n.own = 1'b1;
      end
    end else if (!r[s.g]) begin
      n.acks  = 0;
      n.waits = 0;
      if (r != 5'b0) n.g = next_req(r, s.g, 1'b1);
      else n.own = 1'b0;
    end else if (ack && s.acks >= QUOTA - 1 && (cti == 3'b000 || cti == 3'b111) &&
                 (r & ~(5'(1) << s.g)) != 5'b0) begin
      n.g     = next_req(r, s.g, 1'b0);
      n.acks  = 0;
      n.waits = 0;
    end else begin
      if (ack && s.acks < QUOTA) n.acks = s.acks + 1;
      if (stb && !ack) begin
        n.waits = s.waits + 1;
        if (n.waits == TIMEOUT) begin
          n.pulse = 1'b1;
          n.waits = 0;
        end
      end else begin
        n.waits = 0;
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUT, including async reset.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) m <= '{default: 0};
    else m <= model_step(m, req, bus_stb, bus_ack, bus_cti);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advance one edge and compare every output against the model.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    check("model_gnt", int'(gnt), m.g);
    check("model_busy", int'(busy), int'(m.own));
    check("model_timeout", int'(timeout), int'(m.pulse));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int exp_rr[6];

  initial begin
    exp_rr = '{1, 2, 3, 4, 0, 1};

    // Reset state.
    tick();
    tick();
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
    sys_rst = 1'b0;

    // Lone master 0 is granted after one edge; dropping it parks.
    req = 5'b00001;
    tick();
    check("solo_gnt", int'(gnt), 0);
    check("solo_busy", int'(busy), 1);
    req = 5'b00000;
    tick();
    check("park_busy", int'(busy), 0);
    check("park_gnt", int'(gnt), 0);

    // Round robin: all request, each drops cyc after one ack.
    req = 5'b11111;
    tick();
    check("rr_0", int'(gnt), exp_rr[0]);
    for (int i = 0; i < 5; i++) begin
      bus_stb = 1'b1;
      bus_ack = 1'b1;
      bus_cti = 3'b000;
      req     = 5'b11111;
      tick();
      bus_stb = 1'b0;
      bus_ack = 1'b0;
      req     = 5'b11111 & ~(5'(1) << exp_rr[i]);
      tick();
      check($sformatf("rr_%0d", i + 1), int'(gnt), exp_rr[i + 1]);
    end
    req = 5'b00000;
    tick();
    check("rr_park_busy", int'(busy), 0);
    check("rr_park_gnt", int'(gnt), 1);

    // Quota with classic cycles: master 2 yields to 1 on its 8th ack.
    req = 5'b00100;
    tick();
    check("q_own2", int'(gnt), 2);
    req     = 5'b00110;
    bus_stb = 1'b1;
    bus_ack = 1'b1;
    bus_cti = 3'b000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("q_ack%0d", i), int'(gnt), (i < 8) ? 2 : 1);
    end
    bus_stb = 1'b0;
    bus_ack = 1'b0;

    // 8-beat incrementing burst: only the 111 beat may hand over.
    req = 5'b00100;
    tick();
    check("b_own2", int'(gnt), 2);
    req     = 5'b00110;
    bus_stb = 1'b1;
    bus_ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus_cti = (i < 8) ? 3'b010 : 3'b111;
      tick();
      check($sformatf("b_beat%0d", i), int'(gnt), (i < 8) ? 2 : 1);
    end

    // Constant-address burst past quota never yields; a classic ack then does.
    for (int i = 1; i <= 10; i++) begin
      bus_cti = 3'b001;
      tick();
      check($sformatf("c_beat%0d", i), int'(gnt), 1);
    end
    bus_cti = 3'b000;
    tick();
    check("c_classic", int'(gnt), 2);
    bus_stb = 1'b0;
    bus_ack = 1'b0;

    // Watchdog: master 3 strobes without ack; pulses every 16 wait cycles.
    req = 5'b01000;
    tick();
    check("to_own3", int'(gnt), 3);
    bus_stb = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      check($sformatf("to_pulse%0d", i), int'(timeout), (i % 16 == 0) ? 1 : 0);
      check($sformatf("to_gnt%0d", i), int'(gnt), 3);
    end

    // Drop cyc together with an ack: released to master 0, tenure cleared.
    req     = 5'b00001;
    bus_ack = 1'b1;
    bus_cti = 3'b000;
    tick();
    check("drop_ack_gnt", int'(gnt), 0);
    check("drop_ack_busy", int'(busy), 1);
    check("drop_ack_tenure", int'(dut.tenure_cnt), 0);

    // Master 4 starts a burst, then reset arrives between edges.
    req     = 5'b10000;
    bus_ack = 1'b0;
    bus_stb = 1'b0;
    tick();
    check("r_own4", int'(gnt), 4);
    bus_stb = 1'b1;
    bus_cti = 3'b010;
    bus_ack = 1'b1;
    tick();
    tick();
    bus_ack = 1'b0;
    tick();
    check("r_tenure_pre", int'(dut.tenure_cnt), 2);
    check("r_wait_pre", int'(dut.wait_cnt), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_busy", int'(busy), 0);
    check("async_timeout", int'(timeout), 0);
    check("async_tenure", int'(dut.tenure_cnt), 0);
    check("async_wait", int'(dut.wait_cnt), 0);
    tick();
    sys_rst = 1'b0;
    req     = 5'b00000;
    bus_stb = 1'b0;
    bus_ack = 1'b0;
    bus_cti = 3'b000;
    tick();

    // First grant after reset searches from 1; master 0 comes last.
    req = 5'b00011;
    tick();
    check("post_rst_gnt", int'(gnt), 1);
    req = 5'b00000;
    tick();
    check("post_rst_park", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
